// File: rtl/cu_fsm_if.sv
// Control-unit bundle: instruction fields and interrupt in, datapath strobes and status out.
// The control unit uses the slave view; the datapath (or a bench) drives through master.
interface cu_fsm_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        intr;
  logic        pc_write;
  logic        reg_write;
  logic        mem_we2;
  logic        mem_rden1;
  logic        mem_rden2;
  logic        rst;
  logic        int_taken;
  logic        csr_we;
  logic        mret_exec;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    output opcode, funct3, intr,
    input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
    input  rst, int_taken, csr_we, mret_exec, state, instret
  );

  modport slave (
    input  opcode, funct3, intr,
    output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
    output rst, int_taken, csr_we, mret_exec, state, instret
  );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle RISC-V control unit: INIT/FETCH/EXEC/WB/INTR sequencer with a retired-instruction counter.
// Strobes are a pure decode of the current state and instruction fields.
module cu_fsm (
  input  logic     clk,
  input  logic     rst_n,
  cu_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC  = 3'b010,
    ST_WB    = 3'b011,
    ST_INTR  = 3'b100
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      r_state;
  logic [31:0] r_instret;

  logic w_pc_write;
  logic w_reg_write;
  logic w_mem_we2;
  logic w_mem_rden1;
  logic w_mem_rden2;
  logic w_rst;
  logic w_int_taken;
  logic w_csr_we;
  logic w_mret_exec;

  // State sequencing and retirement count; loads retire from WB, everything else from EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_instret <= 32'd0;
    end else begin
      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (bus.opcode == OP_LOAD) begin
            r_state <= ST_WB;
          end else begin
            r_instret <= r_instret + 32'd1;
            r_state   <= bus.intr ? ST_INTR : ST_FETCH;
          end
        end
        ST_WB: begin
          r_instret <= r_instret + 32'd1;
          r_state   <= bus.intr ? ST_INTR : ST_FETCH;
        end
        ST_INTR:  r_state <= ST_FETCH;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  // Strobe decode; unused encodings fall through with everything low.
  always_comb begin
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_we2   = 1'b0;
    w_mem_rden1 = 1'b0;
    w_mem_rden2 = 1'b0;
    w_rst       = 1'b0;
    w_int_taken = 1'b0;
    w_csr_we    = 1'b0;
    w_mret_exec = 1'b0;
    case (r_state)
      ST_INIT:  w_rst       = 1'b1;
      ST_FETCH: w_mem_rden1 = 1'b1;
      ST_EXEC: begin
        case (bus.opcode)
          OP_LOAD:   w_mem_rden2 = 1'b1;
          OP_STORE: begin
            w_mem_we2  = 1'b1;
            w_pc_write = 1'b1;
          end
          OP_BRANCH: w_pc_write = 1'b1;
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            w_pc_write  = 1'b1;
            w_reg_write = 1'b1;
          end
          OP_SYSTEM: begin
            w_pc_write = 1'b1;
            if (bus.funct3 == 3'b000) begin
              w_mret_exec = 1'b1;
            end else begin
              w_csr_we    = 1'b1;
              w_reg_write = 1'b1;
            end
          end
          default:   w_pc_write = 1'b1;
        endcase
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
      end
      ST_INTR: begin
        w_int_taken = 1'b1;
        w_pc_write  = 1'b1;
      end
      default: w_rst = 1'b0;
    endcase
  end

  assign bus.pc_write  = w_pc_write;
  assign bus.reg_write = w_reg_write;
  assign bus.mem_we2   = w_mem_we2;
  assign bus.mem_rden1 = w_mem_rden1;
  assign bus.mem_rden2 = w_mem_rden2;
  assign bus.rst       = w_rst;
  assign bus.int_taken = w_int_taken;
  assign bus.csr_we    = w_csr_we;
  assign bus.mret_exec = w_mret_exec;
  assign bus.state     = r_state;
  assign bus.instret   = r_instret;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: inputs change and outputs are sampled on the falling clock edge.
module tb_cu_fsm;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cu_fsm_if bus ();

  cu_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus.opcode = 7'b0110011;
    bus.funct3 = 3'b000;
    bus.intr   = 1'b0;
    #13;
    checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state: got %0h expected 0", bus.state); end
    checks++; if (bus.rst !== 1'b1) begin errors++; $display("FAIL reset_rst: got %0b expected 1", bus.rst); end
    checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0h expected 0", bus.instret); end
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_rden1, bus.mem_we2} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %04b expected 0000", {bus.pc_write, bus.reg_write, bus.mem_rden1, bus.mem_we2}); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL release_init: got %0h expected 0", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL first_fetch_state: got %0h expected 1", bus.state); end
    checks++; if ({bus.mem_rden1, bus.rst, bus.pc_write} !== 3'b100) begin errors++; $display("FAIL first_fetch_strobes: got %03b expected 100", {bus.mem_rden1, bus.rst, bus.pc_write}); end
  endtask

  task automatic test_op_sequence;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (bus.state !== 3'b010) begin errors++; $display("FAIL op_exec_state: got %0h expected 2", bus.state); end
      checks++; if ({bus.pc_write, bus.reg_write, bus.mem_rden1} !== 3'b110) begin errors++; $display("FAIL op_exec_strobes: got %03b expected 110", {bus.pc_write, bus.reg_write, bus.mem_rden1}); end
      @(negedge clk);
      checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL op_back_to_fetch: got %0h expected 1", bus.state); end
      checks++; if (bus.instret !== 32'(i)) begin errors++; $display("FAIL op_instret: got %0h expected %0h", bus.instret, i); end
    end
  endtask

  task automatic test_load;
    bus.opcode = 7'b0000011;
    checks++; if (bus.mem_rden1 !== 1'b1) begin errors++; $display("FAIL load_fetch_rden1: got %0b expected 1", bus.mem_rden1); end
    @(negedge clk);
    checks++; if ({bus.mem_rden2, bus.pc_write, bus.reg_write} !== 3'b100) begin errors++; $display("FAIL load_exec_strobes: got %03b expected 100", {bus.mem_rden2, bus.pc_write, bus.reg_write}); end
    @(negedge clk);
    checks++; if (bus.state !== 3'b011) begin errors++; $display("FAIL load_wb_state: got %0h expected 3", bus.state); end
    checks++; if ({bus.reg_write, bus.pc_write, bus.mem_rden2} !== 3'b110) begin errors++; $display("FAIL load_wb_strobes: got %03b expected 110", {bus.reg_write, bus.pc_write, bus.mem_rden2}); end
    checks++; if (bus.instret !== 32'd2) begin errors++; $display("FAIL load_wb_instret: got %0h expected 2", bus.instret); end
    @(negedge clk);
    checks++; if (bus.instret !== 32'd3) begin errors++; $display("FAIL load_retire: got %0h expected 3", bus.instret); end
  endtask

  task automatic test_store_intr;
    bus.opcode = 7'b0100011;
    bus.intr   = 1'b1;
    @(negedge clk);
    checks++; if ({bus.mem_we2, bus.pc_write, bus.reg_write, bus.int_taken} !== 4'b1100) begin errors++; $display("FAIL store_exec_strobes: got %04b expected 1100", {bus.mem_we2, bus.pc_write, bus.reg_write, bus.int_taken}); end
    @(negedge clk);
    checks++; if (bus.state !== 3'b100) begin errors++; $display("FAIL intr_state: got %0h expected 4", bus.state); end
    checks++; if ({bus.int_taken, bus.pc_write, bus.mem_we2} !== 3'b110) begin errors++; $display("FAIL intr_strobes: got %03b expected 110", {bus.int_taken, bus.pc_write, bus.mem_we2}); end
    checks++; if (bus.instret !== 32'd4) begin errors++; $display("FAIL store_instret: got %0h expected 4", bus.instret); end
    @(negedge clk);
    checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL intr_to_fetch: got %0h expected 1", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 3'b010) begin errors++; $display("FAIL no_nested_intr: got %0h expected 2", bus.state); end
    bus.intr = 1'b0;
    @(negedge clk);
    checks++; if (bus.instret !== 32'd5) begin errors++; $display("FAIL store2_instret: got %0h expected 5", bus.instret); end
  endtask

  task automatic test_system;
    bus.opcode = 7'b1110011;
    bus.funct3 = 3'b000;
    @(negedge clk);
    checks++; if ({bus.mret_exec, bus.csr_we, bus.pc_write, bus.reg_write} !== 4'b1010) begin errors++; $display("FAIL mret_strobes: got %04b expected 1010", {bus.mret_exec, bus.csr_we, bus.pc_write, bus.reg_write}); end
    @(negedge clk);
    bus.funct3 = 3'b001;
    @(negedge clk);
    checks++; if ({bus.mret_exec, bus.csr_we, bus.pc_write, bus.reg_write} !== 4'b0111) begin errors++; $display("FAIL csrrw_strobes: got %04b expected 0111", {bus.mret_exec, bus.csr_we, bus.pc_write, bus.reg_write}); end
    @(negedge clk);
    checks++; if (bus.instret !== 32'd7) begin errors++; $display("FAIL system_instret: got %0h expected 7", bus.instret); end
  endtask

  task automatic test_branch_and_nop;
    bus.opcode = 7'b1100011;
    @(negedge clk);
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_we2, bus.csr_we} !== 4'b1000) begin errors++; $display("FAIL branch_strobes: got %04b expected 1000", {bus.pc_write, bus.reg_write, bus.mem_we2, bus.csr_we}); end
    @(negedge clk);
    bus.opcode = 7'b1111111;
    @(negedge clk);
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_rden2, bus.mem_we2} !== 4'b1000) begin errors++; $display("FAIL nop_strobes: got %04b expected 1000", {bus.pc_write, bus.reg_write, bus.mem_rden2, bus.mem_we2}); end
    @(negedge clk);
    checks++; if (bus.instret !== 32'd9) begin errors++; $display("FAIL nop_instret: got %0h expected 9", bus.instret); end
  endtask

  task automatic test_async_reset;
    bus.opcode = 7'b0000011;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.state !== 3'b011) begin errors++; $display("FAIL abort_pre_wb: got %0h expected 3", bus.state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL abort_state: got %0h expected 0", bus.state); end
    checks++; if ({bus.rst, bus.reg_write, bus.pc_write} !== 3'b100) begin errors++; $display("FAIL abort_strobes: got %03b expected 100", {bus.rst, bus.reg_write, bus.pc_write}); end
    checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL abort_instret: got %0h expected 0", bus.instret); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL abort_refetch: got %0h expected 1", bus.state); end
  endtask

  task automatic test_instret_wrap;
    bus.opcode = 7'b0010011;
    bus.funct3 = 3'b000;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    checks++; if (bus.instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffffffff", bus.instret); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.instret !== 32'h0000_0000) begin errors++; $display("FAIL wrap_instret: got %0h expected 0", bus.instret); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_op_sequence();
    test_load();
    test_store_intr();
    test_system();
    test_branch_and_nop();
    test_async_reset();
    test_instret_wrap();
    chk("end_state", {29'd0, bus.state}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
